// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
//   state_t    : controller states (IDLE, SHIFT, DONE)
//   calc_cnt_w : bit-counter width for a given operand width
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Legal widths are 2..32, so $clog2 is always >= 1 here.
   function automatic int calc_cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor_1bit.sv
// Combinational 1-bit full-subtractor cell: Diff = A - B - Bin.
// Ports:
//   A, B, Bin : minuend bit, subtrahend bit, borrow-in
//   Diff      : difference bit
//   Bout      : borrow-out
module full_subtractor_1bit (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);

   assign Diff = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~A & Bin) | (B & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, DIFF = A - B, LSB first, one bit
// per clock through a single full-subtractor cell.
// Ports:
//   clock, rstn   : clock (rising edge), async active-low reset
//   start         : request, sampled only in IDLE
//   a, b          : minuend / subtrahend, captured on the accepted start
//   busy          : high whenever the controller is not IDLE
//   done          : one-cycle pulse, result outputs valid from this cycle
//   diff          : result register (held until the next done)
//   borrow        : final borrow-out, 1 when a < b (unsigned)
//   zero          : 1 when diff == 0
// Build option:
//   SERIAL_SUBTRACTOR_SAT_EN : clamp the result to zero on underflow
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start; operands loaded on accept
// SHIFT | one bit per cycle through the cell, WIDTH cycles
// DONE  | result registers just updated, done pulse high
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero
);

   localparam int CNT_W = calc_cnt_w(WIDTH);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q, a_sh_d;
   logic [WIDTH-1:0]   b_sh_q, b_sh_d;
   // Only the WIDTH-1 earlier bits are stored; the final bit comes straight
   // from the cell in the last SHIFT cycle.
   logic [WIDTH-2:0]   d_sh_q, d_sh_d;
   logic               brw_q, brw_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic               borrow_q, borrow_d;
   logic               zero_q, zero_d;

   logic               cell_d;
   logic               cell_bout;
   logic [WIDTH-1:0]   d_full;

   full_subtractor_1bit u_cell (
      .A    (a_sh_q[0]),
      .B    (b_sh_q[0]),
      .Bin  (brw_q),
      .Diff (cell_d),
      .Bout (cell_bout)
   );

   assign d_full = {cell_d, d_sh_q};

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      d_sh_d   = d_sh_q;
      brw_d    = brw_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               brw_d   = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            brw_d  = cell_bout;
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            d_sh_d = d_full[WIDTH-1:1];
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d  = DONE;
               diff_d   = d_full;
               borrow_d = cell_bout;
               zero_d   = (d_full == '0);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
               if (cell_bout) begin
                  diff_d = '0;
                  zero_d = 1'b1;
               end
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         d_sh_q   <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         d_sh_q   <= d_sh_d;
         brw_q    <= brw_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results are
// queued when an operation is accepted and compared when done pulses.
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clock = 1'b0;
   logic             rstn  = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a_i   = '0;
   logic [WIDTH-1:0] b_i   = '0;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             zero;

   typedef struct packed {
      logic [WIDTH-1:0] diff;
      logic             borrow;
      logic             zero;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp = '0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   last_done_cyc = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clock  (clock),
      .rstn   (rstn),
      .start  (start),
      .a      (a_i),
      .b      (b_i),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow),
      .zero   (zero)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      e.diff   = a - b;
      e.borrow = (a < b);
      e.zero   = (e.diff == '0);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      if (e.borrow) begin
         e.diff = '0;
         e.zero = 1'b1;
      end
`endif
      return e;
   endfunction

   always @(negedge clock) begin : mon
      exp_t e;
      if (rstn && done) begin
         done_cnt++;
         last_done_cyc = cyc;
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("diff",   32'(diff),   32'(e.diff));
            chk("borrow", 32'(borrow), 32'(e.borrow));
            chk("zero",   32'(zero),   32'(e.zero));
            last_exp = e;
         end
      end
   end

   // Issue one operation, check outputs hold during it, its latency and
   // that done lasts one cycle. Operand inputs are scrambled after accept.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int lat;
      @(negedge clock);
      a_i = a; b_i = b; start = 1'b1;
      @(posedge clock);
      sb.push_back(model(a, b));
      #1;
      start = 1'b0; a_i = ~a; b_i = 8'h5A;
      chk("busy_after_accept", 32'(busy), 32'd1);
      chk("hold_diff", 32'(diff), 32'(last_exp.diff));
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clock); #1;
         if (!done) chk("busy_during_op", 32'(busy), 32'd1);
         lat++;
      end
      chk("latency", 32'(lat), 32'(WIDTH + 1));
      chk("busy_at_done", 32'(busy), 32'd1);
      @(posedge clock); #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int d0;
      int lat;
      int tms[3];

      #12;
      chk("rst_busy",   32'(busy),   32'd0);
      chk("rst_done",   32'(done),   32'd0);
      chk("rst_diff",   32'(diff),   32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      chk("rst_zero",   32'(zero),   32'd0);
      @(negedge clock); rstn = 1'b1;
      repeat (2) @(posedge clock);

      run_op(8'h0F, 8'h01);
      run_op(8'h00, 8'h01);
      run_op(8'h55, 8'h55);
      run_op(8'hA0, 8'h0A);

      // start pulses during SHIFT and DONE must be ignored
      d0 = done_cnt;
      @(negedge clock);
      a_i = 8'h80; b_i = 8'h01; start = 1'b1;
      @(posedge clock);
      sb.push_back(model(8'h80, 8'h01));
      #1 start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clock); #1;
         lat++;
         if (lat == 3) begin
            start = 1'b1; a_i = 8'h10; b_i = 8'h10;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b1; a_i = 8'h10; b_i = 8'h10;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (12) @(posedge clock);
      #1;
      chk("ignored_start_dones", 32'(done_cnt - d0), 32'd1);
      chk("ignored_start_idle", 32'(busy), 32'd0);

      // reset in the middle of an operation
      @(negedge clock);
      a_i = 8'h33; b_i = 8'h11; start = 1'b1;
      @(posedge clock);
      sb.push_back(model(8'h33, 8'h11));
      #1 start = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      rstn = 1'b0;
      sb.delete();
      last_exp = '0;
      #1;
      chk("midrst_busy",   32'(busy),   32'd0);
      chk("midrst_done",   32'(done),   32'd0);
      chk("midrst_diff",   32'(diff),   32'd0);
      chk("midrst_borrow", 32'(borrow), 32'd0);
      chk("midrst_zero",   32'(zero),   32'd0);
      d0 = done_cnt;
      @(negedge clock); rstn = 1'b1;
      repeat (14) @(posedge clock);
      #1;
      chk("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
      run_op(8'h03, 8'h02);

      // start held high: one result every WIDTH+2 cycles
      d0 = done_cnt;
      @(negedge clock);
      a_i = 8'h20; b_i = 8'h10; start = 1'b1;
      for (int k = 0; k < 3; k++) sb.push_back(model(8'h20, 8'h10));
      for (int k = 0; k < 3; k++) begin
         int g;
         g = 0;
         while (done_cnt < d0 + k + 1 && g < 40) begin
            @(negedge clock); #1;
            g++;
         end
         tms[k] = last_done_cyc;
      end
      start = 1'b0;
      chk("held_dones", 32'(done_cnt - d0), 32'd3);
      chk("held_spacing_1", 32'(tms[1] - tms[0]), 32'(WIDTH + 2));
      chk("held_spacing_2", 32'(tms[2] - tms[1]), 32'(WIDTH + 2));
      repeat (4) @(posedge clock);
      #1;
      chk("held_idle", 32'(busy), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
